// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (IFU) and load/store (LSU), one transaction in flight.
// Build option ARB_ROUND_ROBIN_EN selects round-robin arbitration; without it the LSU has fixed priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,

  output logic        busy
);

  // state  | meaning
  // S_IDLE | no transaction; ready offered to the arbitration winner
  // S_REQ  | mem_req_valid driven with latched fields until mem_req_ready
  // S_RESP | waiting for mem_resp_valid, forwarded to the owner
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_owner;
  logic [31:0] r_addr;
  logic        r_wen;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;

  logic        w_grant_lsu;
  logic        w_accept;

  assign w_accept = (r_state == S_IDLE) && (ifu_req_valid || lsu_req_valid);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  // On contention, hand the port to whoever did not win last time.
  always_comb begin
    if (ifu_req_valid && lsu_req_valid) begin
      w_grant_lsu = (r_last_grant == OWN_IFU);
    end else begin
      w_grant_lsu = lsu_req_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= OWN_LSU;
    end else if (w_accept) begin
      r_last_grant <= w_grant_lsu;
    end
  end
`else
  always_comb begin
    w_grant_lsu = lsu_req_valid;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept)       w_next_state = S_REQ;
      S_REQ:  if (mem_req_ready)  w_next_state = S_RESP;
      S_RESP: if (mem_resp_valid) w_next_state = S_IDLE;
      default:                    w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    busy           = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        ifu_req_ready = ifu_req_valid && !w_grant_lsu;
        lsu_req_ready = lsu_req_valid && w_grant_lsu;
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
      end
      S_RESP: begin
        // Suppressed during reset so an abandoned transaction never pulses.
        ifu_resp_valid = mem_resp_valid && !reset && (r_owner == OWN_IFU);
        lsu_resp_valid = mem_resp_valid && !reset && (r_owner == OWN_LSU);
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= OWN_IFU;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_accept) begin
      r_owner <= w_grant_lsu;
      if (w_grant_lsu) begin
        r_addr  <= lsu_addr;
        r_wen   <= lsu_wen;
        r_wdata <= lsu_wdata;
        r_wmask <= lsu_wmask;
      end else begin
        r_addr  <= ifu_addr;
        r_wen   <= 1'b0;
        r_wdata <= '0;
        r_wmask <= 4'hF;
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wen   = r_wen;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wmask;
  assign ifu_rdata = mem_rdata;
  assign lsu_rdata = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: ifu_req_valid  input  1 / ifu_req_ready  output  1 / ifu_addr  input  32  instruction-fetch read request (always 4-byte read).
REQ-004 SHALL have: ifu_resp_valid  output  1 / ifu_rdata  output  32  fetch response.
REQ-005 SHALL have: lsu_req_valid  input  1 / lsu_req_ready  output  1 / lsu_addr  input  32 / lsu_wen  input  1 / lsu_wdata  input  32 / lsu_wmask  input  4  load/store request.
REQ-006 SHALL have: lsu_resp_valid  output  1 / lsu_rdata  output  32  load data or store acknowledge.
REQ-007 SHALL have: mem_req_valid  output  1 / mem_req_ready  input  1 / mem_addr  output  32 / mem_wen  output  1 / mem_wdata  output  32 / mem_wmask  output  4  shared memory port request.
REQ-008 SHALL have: mem_resp_valid  input  1 / mem_rdata  input  32  shared memory port response.
REQ-009 SHALL have: busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, REQ, RESP; at most one outstanding memory transaction.
REQ-011 In IDLE, SHALL assert ready (combinationally) to exactly one requester: the arbitration winner among those with valid high; no ready when neither valid.
REQ-012 Acceptance = valid & ready in IDLE; SHALL register addr/wen/wdata/wmask (IFU: wen=0, wmask=4'hF) and owner ID, then go to REQ next cycle.
REQ-013 In REQ, SHALL drive mem_req_valid=1 with registered fields held stable until mem_req_ready=1; then go to RESP.
REQ-014 In RESP, on mem_resp_valid=1 SHALL forward mem_rdata and pulse owner's resp_valid for that same cycle only (combinational pass-through), then return to IDLE.
REQ-015 Non-owner resp_valid SHALL stay 0; ifu_rdata/lsu_rdata SHALL equal mem_rdata (qualified by resp_valid).
REQ-016 mem_resp_valid outside RESP (including the REQ acceptance cycle) SHALL be ignored with no state change.
REQ-017 Stores (lsu_wen=1) SHALL also complete through RESP; lsu_resp_valid pulse acknowledges the write.
REQ-018 Both ready outputs SHALL be 0 in REQ and RESP; requesters hold valid until accepted.
REQ-019 Best-case request-to-response: accept at cycle N, mem_req_valid at N+1, response no earlier than N+2.
REQ-020 Request arriving the cycle a response returns SHALL be accepted no earlier than the following (IDLE) cycle.

Reset
REQ-021 Reset SHALL force state=IDLE, owner=IFU, last_grant=LSU, registered request fields=0.
REQ-022 All outputs after reset: mem_req_valid=0, resp_valid=0, busy=0, mem_addr/mem_wdata=0, mem_wen=0, mem_wmask=0.
REQ-023 Reset mid-transaction SHALL abandon it: no resp_valid pulse for it; a late mem_resp_valid is ignored per REQ-016.

Configuration
REQ-024 Macro ARB_ROUND_ROBIN_EN defined: when both valid, grant the requester not in last_grant; last_grant updates on each acceptance.
REQ-025 Macro undefined: fixed priority, LSU always wins when both valid; last_grant register omitted.

Verification
REQ-026 Single fetch: ifu_addr=0x80000000, mem_req_ready=1, response 2 cycles later with 0x00100073 -> ifu_resp_valid one cycle, ifu_rdata=0x00100073, lsu_resp_valid=0.
REQ-027 Store: lsu_addr=0x80001000, wen=1, wdata=0xDEADBEEF, wmask=0xF -> mem_* carry identical values, held through 3 cycles of mem_req_ready=0; one lsu_resp_valid pulse.
REQ-028 Both valid continuously for 4 transactions: with ARB_ROUND_ROBIN_EN grants IFU,LSU,IFU,LSU; without, LSU,LSU,LSU,LSU.
REQ-029 Reset asserted in RESP, then mem_resp_valid=1 -> neither resp_valid pulses, busy=0, next fetch proceeds normally.
REQ-030 Spurious mem_resp_valid=1 in IDLE and in REQ -> no resp_valid, no state change; mem_req_valid remains asserted in REQ.
